// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: instruction-memory read port, redirect input,
// decoder-facing valid/ready instruction port and optional statistics.
// The master side is the fetch queue; the slave side is the environment
// (instruction memory plus decode/control stage).
interface inst_fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic [31:0]   inst;
    logic [31:0]   inst_pc;
    logic [5:0]    OpCode;
    logic [5:0]    Funct;
    logic [CW-1:0] queue_count;
    logic [31:0]   stat_fetched;
    logic [31:0]   stat_flushes;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        input  redirect, redirect_pc,
        output inst_valid, inst, inst_pc, OpCode, Funct, queue_count,
        input  inst_ready,
        output stat_fetched, stat_flushes
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        output redirect, redirect_pc,
        input  inst_valid, inst, inst_pc, OpCode, Funct, queue_count,
        output inst_ready,
        input  stat_fetched, stat_flushes
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: generates the PC, issues one-cycle-latency
// instruction-memory reads and buffers returned words with their PCs in a
// small circular queue that feeds the decoder over valid/ready.
// Optional statistics counters are built when FETCH_STATS_EN is defined;
// otherwise stat_fetched/stat_flushes read as zero.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    inst_fetch_queue_if.master bus
);
    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(DEPTH);

    // Queue storage: written only from the tail, read combinationally at the head.
    logic [31:0] word_mem_q [DEPTH];
    logic [31:0] pc_mem_q   [DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          pending_q, pending_d;
    logic [31:0]   pending_pc_q, pending_pc_d;
    logic [31:0]   pc_q, pc_d;

    logic          pop;
    logic          req;
    logic          push;
    logic [CW:0]   occ;

    // Low address bits of a redirect target are forced to zero.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    // Handshake and request decision. The request looks at occupancy after
    // this cycle's pop so a full queue being drained still fetches every cycle.
    always_comb begin
        pop  = (count_q != '0) & bus.inst_ready;
        occ  = {1'b0, count_q} + (CW + 1)'(pending_q) - (CW + 1)'(pop);
        req  = !reset & !bus.redirect & (occ < DEPTH_V);
        push = pending_q & !reset & !bus.redirect;
    end

    // Next-state for PC, pointers, count and the in-flight read tracker.
    always_comb begin
        pc_d         = pc_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        pending_d    = pending_q;
        pending_pc_d = pending_pc_q;
        if (bus.redirect) begin
            // Flush: drop queued entries and any response arriving now.
            pc_d      = {bus.redirect_pc[31:2], 2'b00};
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pending_d = 1'b0;
        end else begin
            pending_d = req;
            if (req) begin
                pc_d         = pc_q + 32'd4;
                pending_pc_d = pc_q;
            end
            if (pending_q) begin
                tail_d = tail_q + AW'(1);
            end
            if (pop) begin
                head_d = head_q + AW'(1);
            end
            count_d = count_q + CW'(pending_q) - CW'(pop);
        end
    end

    // Control state register; reset takes priority over redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
        end else begin
            pc_q         <= pc_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    // Capture the returning read word with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem_q[tail_q] <= bus.imem_rdata;
            pc_mem_q[tail_q]   <= pending_pc_q;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc_q;
    assign bus.inst_valid  = (count_q != '0);
    assign bus.inst        = word_mem_q[head_q];
    assign bus.inst_pc     = pc_mem_q[head_q];
    assign bus.OpCode      = word_mem_q[head_q][31:26];
    assign bus.Funct       = word_mem_q[head_q][5:0];
    assign bus.queue_count = count_q;

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_fetched_d;
    logic [31:0] stat_flushes_q, stat_flushes_d;

    // Counter increments: every accepted instruction, every redirect cycle.
    always_comb begin
        stat_fetched_d = stat_fetched_q + (pop ? 32'd1 : 32'd0);
        stat_flushes_d = stat_flushes_q + (bus.redirect ? 32'd1 : 32'd0);
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_flushes_q <= stat_flushes_d;
        end
    end

    assign bus.stat_fetched = stat_fetched_q;
    assign bus.stat_flushes = stat_flushes_q;
`else
    assign bus.stat_fetched = 32'd0;
    assign bus.stat_flushes = 32'd0;
`endif
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction-side producer for the decode/control stage: generates PC, issues instruction-memory reads, buffers returned words in a small FIFO.
- Presents each instruction word with its OpCode/Funct fields and PC to the decoder over a valid/ready handshake.
- Flushes on PC redirect from jump/branch resolution.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; must be word-aligned.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  read request this cycle
- imem_addr  output  32  word-aligned read address; valid when imem_req=1
- imem_rdata  input  32  read data, valid exactly one cycle after the request
- redirect  input  1  flush and restart fetch (jump/branch/jr taken)
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored, treated as 00
- inst_valid  output  1  head entry valid
- inst_ready  input  1  decoder accepts head entry
- inst  output  32  head instruction word
- inst_pc  output  32  PC of the head instruction
- OpCode  output  6  inst[31:26]
- Funct  output  6  inst[5:0]
- queue_count  output  clog2(DEPTH)+1  entries held
- stat_fetched  output  32  instructions delivered (optional feature)
- stat_flushes  output  32  redirects taken (optional feature)

Behaviour:
- State: pc register, circular queue (DEPTH x {word, pc}) with head/tail pointers and count, pending flag plus pending_pc for the in-flight read.
- Reset: pc=RESET_PC, count=0, pointers=0, pending=0, inst_valid=0, queue_count=0, stats=0. imem_req=0 while reset=1.
- pop = inst_valid & inst_ready. occ = count + pending - pop.
- imem_req = !reset & !redirect & (occ < DEPTH). This is combinational on inst_ready.
- imem_addr = pc. On request: pc <= pc+4, pending <= 1, pending_pc <= pc. Otherwise pending <= 0.
- Response: when pending=1, write {imem_rdata, pending_pc} at tail, tail++ (wraps mod DEPTH).
- Push and pop in the same cycle: count unchanged.
- Invariant count + pending <= DEPTH; the queue is never written when full.
- Outputs come from head storage and are stable while inst_valid=1 and inst_ready=0. inst_valid = (count != 0).
- Latency: request in cycle N -> entry in queue at end of N+1 -> inst_valid in N+2.
- Throughput: with inst_ready held high, one instruction per cycle in steady state for any DEPTH >= 2.
- Redirect in cycle T (overrides everything):
  - In cycle T: no request; any response arriving in T is discarded.
  - Next cycle: count=0, head=tail=0, pending=0, pc=redirect_pc.
  - A pop in T still counts as accepted by the consumer.
  - First request at redirect_pc in T+1; inst_valid again at T+3.
- Reset asserted mid-operation: same as redirect, with pc=RESET_PC and stats cleared.
- Reset and redirect together: reset wins.
- pc wraps modulo 2^32 with no special handling.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - stat_fetched increments on every pop.
  - stat_flushes increments on every redirect cycle while not in reset.
  - Both are 32-bit, wrap on overflow, and are cleared by reset.
- Undefined: no counter registers; stat_fetched and stat_flushes tied to 0.

Test Plan:
- Stream: release reset, inst_ready=1, memory returns rdata=addr^32'hA5A5_0000.
  - imem_addr 0x0 in cycle 0; inst_valid in cycle 2 with inst_pc=0x0, inst=0xA5A5_0000.
  - Then one instruction per cycle: pc 0x4, 0x8, ... with no bubbles.
- Backpressure: inst_ready=0 from start.
  - Exactly 4 requests issued (0x0-0xC); imem_req then stays 0 and queue_count=4.
  - inst stays 0xA5A5_0000.
  - Raise inst_ready: entries drain in order 0x0,0x4,0x8,0xC, then fetch resumes at 0x10.
- Redirect with read in flight (count=2, pending=1), redirect_pc=0x0000_0103:
  - Next cycle queue_count=0, inst_valid=0, imem_addr=0x100.
  - Stale response dropped; next delivered inst_pc=0x100, 2 cycles after that request.
- Field decode:
  - rdata 0x0000_0008 -> OpCode=0x00, Funct=0x08.
  - rdata 0x8C08_0004 -> OpCode=0x23, Funct=0x04.
  - rdata 0x0800_0010 -> OpCode=0x02.
- Reset mid-stream with count=3, pending=1:
  - Next cycle queue_count=0, inst_valid=0, imem_req=0.
  - After release, imem_addr=RESET_PC.
  - Reset+redirect same cycle -> RESET_PC used.
- Stats: with FETCH_STATS_EN, 5 pops and 2 redirects -> stat_fetched=5, stat_flushes=2; reset -> both 0. Without the macro, both read 0 throughout.
